muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_sign_fix.sv | 55 +++++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// opcode and FSM encodings plus width and overflow constants.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // All divide/remainder opcodes live in the upper half of the funct3 space.
  function automatic logic op_is_div(logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand-to-magnitude conversion at issue time
// and sign correction / result selection when the iteration finishes.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            a_neg,
  output logic            b_neg,
  input  logic [2:0]      op_fix,
  input  logic            a_neg_fix,
  input  logic            b_neg_fix,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] result
);

  logic a_signed;
  logic b_signed;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  always_comb begin
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  end

  assign a_neg = a_signed & a_in[XLEN-1];
  assign b_neg = b_signed & b_in[XLEN-1];
  assign mag_a = a_neg ? (-a_in) : a_in;
  assign mag_b = b_neg ? (-b_in) : b_in;

  // Flags were captured already qualified by signedness, so unsigned ops pass through.
  always_comb begin
    prod     = {hi_in, lo_in};
    prod_fix = (a_neg_fix ^ b_neg_fix) ? (-prod) : prod;
    quo_fix  = (a_neg_fix ^ b_neg_fix) ? (-lo_in) : lo_in;
    rem_fix  = a_neg_fix ? (-hi_in) : hi_in;
    case (op_fix)
      OP_MUL:                        result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = quo_fix;
      default:                       result = rem_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: XLEN shift-add or restoring-division
// steps on magnitudes, one finishing cycle for sign fix, then a done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              write_back_en
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] CALC = ST_CALC;
  localparam logic [1:0] DONE = ST_DONE;

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  OVF_A    = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        op_reg;
  logic              a_neg_reg;
  logic              b_neg_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic [XLEN-1:0]   hi_reg;
  logic [XLEN-1:0]   lo_reg;
  logic [XLEN-1:0]   result_reg;
  logic [ADDR_W-1:0] wr_addr_reg;

  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] fixed_result;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_in     (funct3),
    .a_in      (rs1_data),
    .b_in      (rs2_data),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .op_fix    (op_reg),
    .a_neg_fix (a_neg_reg),
    .b_neg_fix (b_neg_reg),
    .hi_in     (hi_reg),
    .lo_in     (lo_reg),
    .result    (fixed_result)
  );

  // Divide corner cases bypass the iteration entirely.
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    div_zero    = op_is_div(funct3) && (rs2_data == '0);
    div_ovf     = op_is_div(funct3) && !funct3[0] &&
                  (rs1_data == OVF_A) && (rs2_data == '1);
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? rs1_data : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : OVF_A;
  end

  // One iteration step; hi/lo hold product halves or remainder/quotient.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ok;
  logic [XLEN-1:0] hi_next;
  logic [XLEN-1:0] lo_next;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? opnd_reg : '0)};
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_ok    = ~div_diff[XLEN];
    if (op_is_div(op_reg)) begin
      hi_next = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_next = {lo_reg[XLEN-2:0], div_ok};
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      a_neg_reg   <= 1'b0;
      b_neg_reg   <= 1'b0;
      opnd_reg    <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      result_reg  <= '0;
      wr_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg      <= funct3;
            wr_addr_reg <= rd_addr;
            a_neg_reg   <= a_neg;
            b_neg_reg   <= b_neg;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            if (op_is_div(funct3)) begin
              opnd_reg <= mag_b;
              lo_reg   <= mag_a;
            end else begin
              opnd_reg <= mag_a;
              lo_reg   <= mag_b;
            end
            if (div_zero || div_ovf) begin
              result_reg <= special_res;
              state_reg  <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt_reg == LAST_CNT) begin
            result_reg <= fixed_result;
            state_reg  <= DONE;
          end else begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign write_back_en = done;
  assign result        = result_reg;
  assign wr_addr       = wr_addr_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model, per-cycle
// compare process, directed corner cases and randomized back-to-back starts.
module tb_muldiv_unit;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int LAT    = XLEN + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;
  logic [ADDR_W-1:0] wr_addr;
  logic              write_back_en;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .funct3        (funct3),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rd_addr       (rd_addr),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .wr_addr       (wr_addr),
    .write_back_en (write_back_en)
  );

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [4:0]  wa;
  } exp_t;

  exp_t exp_q[$];
  int   cyc        = 0;
  int   busy_until = -1;
  int   n_tests    = 0;
  int   n_fail     = 0;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = 0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycles from the accepting edge to the cycle where done is visible.
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return LAT;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare process: runs just after every rising edge.
  initial begin
    logic exp_done;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("busy", {31'b0, busy}, {31'b0, (cyc <= busy_until)});
      check("done", {31'b0, done}, {31'b0, exp_done});
      check("write_back_en", {31'b0, write_back_en}, {31'b0, exp_done});
      if (exp_done) begin
        check("result", result, exp_q[0].res);
        check("wr_addr", {27'b0, wr_addr}, {27'b0, exp_q[0].wa});
        $display("[TB] cycle %0d: result %h wr_addr %0d", cyc, result, wr_addr);
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at a falling edge; the model decides whether the next edge accepts it.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    start    = 1'b1;
    funct3   = op;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    if (!rst && cyc > busy_until) begin
      e.due = cyc + 1 + lat_of(op, a, b);
      e.res = model(op, a, b);
      e.wa  = rd;
      exp_q.push_back(e);
      busy_until = e.due;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && cyc <= busy_until; k++) @(negedge clk);
    if (cyc <= busy_until) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    wait_idle();
    drive(op, a, b, rd);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    busy_until = cyc;
  endtask

  function automatic logic [31:0] rnd_opnd();
    int s;
    s = int'($urandom_range(0, 7));
    case (s)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return 32'(-int'($urandom_range(1, 20)));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  t_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] t_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] t_b  [12] = '{32'd5, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] t_r  [12] = '{32'd35, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h1,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    funct3   = 3'd0;
    rs1_data = '0;
    rs2_data = '0;
    rd_addr  = '0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_wr_addr", {27'b0, wr_addr}, 32'h0);
    rst = 1'b0;

    // Pin the model, then run each case through the DUT.
    check("pin_lat_mul", lat_of(3'd0, 32'd7, 32'd5), 32'd33);
    check("pin_lat_div0", lat_of(3'd5, 32'd5, 32'd0), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("pin_model_%0d", i), model(t_op[i], t_a[i], t_b[i]), t_r[i]);
      run_op(t_op[i], t_a[i], t_b[i], 5'(i + 1));
    end

    // Re-pulse while busy is ignored; result stays 3*4.
    check("pin_mul_3x4", model(3'd0, 32'd3, 32'd4), 32'd12);
    wait_idle();
    drive(3'd0, 32'd3, 32'd4, 5'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    drive(3'd0, 32'd9, 32'd9, 5'd7);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Abort mid-calculation: no done may follow.
    drive(3'd0, 32'd5, 32'd6, 5'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Random traffic: starts arrive at any time, occasionally with reset.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 2) == 0)
        drive(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom));
      else begin
        start    = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    wait_idle();

    // Result holds outside done, and reset clears it.
    run_op(3'd0, 32'd7, 32'd5, 5'd9);
    @(negedge clk);
    check("hold_result", result, 32'd35);
    check("hold_wr_addr", {27'b0, wr_addr}, 32'd9);
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    check("rst_result", result, 32'h0);
    check("rst_wr_addr", {27'b0, wr_addr}, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
